// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement queue for the out-of-order core. Dispatch allocates
//   an entry at the tail and receives its tag, the writeback bus marks
//   entries complete by tag, and the oldest entry retires from the head
//   once it is complete. Retirement drives the renamer's register-write
//   indication and returns the superseded physical register. A flush
//   discards every in-flight entry in one cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   alloc_valid         dispatch presents an instruction
//   alloc_uses_rw       instruction writes a destination register
//   alloc_rw_phy        new destination physical register
//   alloc_old_phy       previous mapping, freed at commit
//   alloc_ready         an entry is free (no bypass from same-cycle commit)
//   alloc_tag           tag the presented instruction receives (tail)
//   wb_valid, wb_tag    execute completion for an entry
//   flush               branch mispredict, discard everything
//   commit_valid        head entry retires this cycle
//   commit_reg_wr_en    retiring entry writes a register
//   commit_phy          retiring destination physical register
//   commit_old_phy      physical register returned to the free list
//   commit_tag          tag of the retiring entry (head)
//   count               number of occupied entries
module reorder_buffer #(
  parameter int ROB_DEPTH      = 16,
  parameter int ROB_DEPTH_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  input  logic                      alloc_uses_rw,
  input  logic [5:0]                alloc_rw_phy,
  input  logic [5:0]                alloc_old_phy,
  output logic                      alloc_ready,
  output logic [ROB_DEPTH_BITS-1:0] alloc_tag,
  input  logic                      wb_valid,
  input  logic [ROB_DEPTH_BITS-1:0] wb_tag,
  input  logic                      flush,
  output logic                      commit_valid,
  output logic                      commit_reg_wr_en,
  output logic [5:0]                commit_phy,
  output logic [5:0]                commit_old_phy,
  output logic [ROB_DEPTH_BITS-1:0] commit_tag,
  output logic [ROB_DEPTH_BITS:0]   count
);

  localparam logic [ROB_DEPTH_BITS:0] FULL_COUNT = (ROB_DEPTH_BITS+1)'(ROB_DEPTH);
  localparam logic [ROB_DEPTH_BITS:0] ONE_COUNT  = (ROB_DEPTH_BITS+1)'(1);
  localparam logic [ROB_DEPTH_BITS-1:0] ONE_PTR  = ROB_DEPTH_BITS'(1);

  logic [ROB_DEPTH-1:0]      valid_q;
  logic [ROB_DEPTH-1:0]      done_q;
  logic [ROB_DEPTH-1:0]      uses_rw_q;
  logic [5:0]                rw_phy_q  [ROB_DEPTH];
  logic [5:0]                old_phy_q [ROB_DEPTH];
  logic [ROB_DEPTH_BITS-1:0] head_q;
  logic [ROB_DEPTH_BITS-1:0] tail_q;
  logic [ROB_DEPTH_BITS:0]   count_q;

  logic alloc_fire;

  // Readiness looks only at the registered count, so a full buffer stays
  // closed for the cycle in which its head retires.
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;

  assign commit_valid     = valid_q[head_q] & done_q[head_q] & ~flush;
  assign commit_reg_wr_en = commit_valid & uses_rw_q[head_q];
  assign commit_phy       = commit_valid ? rw_phy_q[head_q]  : 6'd0;
  assign commit_old_phy   = commit_valid ? old_phy_q[head_q] : 6'd0;
  assign commit_tag       = head_q;
  assign count            = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      done_q    <= '0;
      uses_rw_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rw_phy_q[i]  <= 6'd0;
        old_phy_q[i] <= 6'd0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // The tail slot is never valid while allocation is possible, so a
      // writeback cannot collide with the done clear of a new entry.
      if (wb_valid && valid_q[wb_tag]) begin
        done_q[wb_tag] <= 1'b1;
      end

      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + ONE_PTR;
      end

      if (alloc_fire) begin
        valid_q[tail_q]   <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        uses_rw_q[tail_q] <= alloc_uses_rw;
        rw_phy_q[tail_q]  <= alloc_rw_phy;
        old_phy_q[tail_q] <= alloc_old_phy;
        tail_q            <= tail_q + ONE_PTR;
      end

      case ({alloc_fire, commit_valid})
        2'b10:   count_q <= count_q + ONE_COUNT;
        2'b01:   count_q <= count_q - ONE_COUNT;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
